// File: rtl/instr_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch front end.
package instr_prefetch_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fifo_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// First-word-fall-through FIFO of {pc, instr}; flush empties it in one cycle.
module prefetch_fifo
    import instr_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_push,
    input  fifo_entry_t            i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output fifo_entry_t            o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);

    fifo_entry_t   r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic          w_pop_ok;

    assign w_pop_ok = i_pop && (r_count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch.sv
// Fetch FSM: assembles 16-bit instructions from two byte reads and feeds decode
// through the prefetch FIFO, with redirect/flush handling.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   reset_n,
    output logic                   mem_req,
    output logic [15:0]            mem_addr,
    input  logic                   mem_ack,
    input  logic [7:0]             mem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [15:0]            instr_data,
    output logic [15:0]            instr_pc,
    input  logic                   redirect,
    input  logic [15:0]            redirect_pc,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t      r_state;
    logic [15:0] r_fetch_pc;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_lo;

    logic [15:0]   w_target;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_next;
    fifo_entry_t   w_push_entry;
    fifo_entry_t   w_head;

    assign w_target     = redirect_pc & 16'hFFFE;
    assign w_push       = (r_state == FETCH_HI) && mem_ack && !redirect;
    assign w_pop        = instr_valid && instr_ready;
    assign w_push_entry = '{pc: r_fetch_pc, instr: {mem_rdata, r_lo}};

    // Occupancy after this cycle's push/pop decides whether to keep fetching.
    always_comb begin
        w_count_next = fifo_count;
        if (w_push && !w_pop)      w_count_next = fifo_count + 1'b1;
        else if (!w_push && w_pop) w_count_next = fifo_count - 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
            r_lo       <= '0;
        end else if (redirect) begin
            r_fetch_pc <= w_target;
            // An unacknowledged request must complete before the bus is reused.
            if (mem_req && !mem_ack) begin
                r_state <= DRAIN;
            end else begin
                r_state    <= FETCH_LO;
                r_mem_addr <= w_target;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (fifo_count < CW'(DEPTH)) begin
                        r_state    <= FETCH_LO;
                        r_mem_addr <= r_fetch_pc;
                    end
                end
                FETCH_LO: begin
                    if (mem_ack) begin
                        r_lo       <= mem_rdata;
                        r_state    <= FETCH_HI;
                        r_mem_addr <= r_fetch_pc + 16'd1;
                    end
                end
                FETCH_HI: begin
                    if (mem_ack) begin
                        r_fetch_pc <= r_fetch_pc + 16'd2;
                        if (w_count_next < CW'(DEPTH)) begin
                            r_state    <= FETCH_LO;
                            r_mem_addr <= r_fetch_pc + 16'd2;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (mem_ack) begin
                        r_state    <= FETCH_LO;
                        r_mem_addr <= r_fetch_pc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_req  = (r_state != IDLE);
    assign mem_addr = r_mem_addr;

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_head  (w_head),
        .o_count (fifo_count)
    );

    assign instr_valid = (fifo_count != '0);
    assign instr_data  = w_head.instr;
    assign instr_pc    = w_head.pc;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: cycle table for streaming/backpressure,
// hand sequences for wait-state drain, redirect collisions, wrap and async reset.
module tb_instr_prefetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;
    int wait_states = 0;
    int wc = 0;

    instr_prefetch #(
        .DEPTH    (4),
        .RESET_PC (16'h0100)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        if (a == 16'h0100) return 8'h34;
        if (a == 16'h0101) return 8'h12;
        return a[7:0] + 8'h5A;
    endfunction

    // Program memory with a programmable number of wait states.
    always_comb begin
        mem_ack   = mem_req && (wc >= wait_states);
        mem_rdata = mem_byte(mem_addr);
    end

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wc <= wc + 1;
        else                     wc <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int ws);
        @(posedge clk);
        #1;
        reset_n     = 1'b0;
        wait_states = ws;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct packed {
        logic        rdy;
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] data;
        logic [15:0] pc;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vt [22];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;

        vt[0]  = '{1'b1, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000, 3'd0};
        vt[1]  = '{1'b1, 1'b1, 16'h0101, 1'b0, 16'h0000, 16'h0000, 3'd0};
        vt[2]  = '{1'b1, 1'b1, 16'h0102, 1'b1, 16'h1234, 16'h0100, 3'd1};
        vt[3]  = '{1'b1, 1'b1, 16'h0103, 1'b0, 16'h0000, 16'h0000, 3'd0};
        vt[4]  = '{1'b1, 1'b1, 16'h0104, 1'b1, 16'h5D5C, 16'h0102, 3'd1};
        vt[5]  = '{1'b1, 1'b1, 16'h0105, 1'b0, 16'h0000, 16'h0000, 3'd0};
        vt[6]  = '{1'b1, 1'b1, 16'h0106, 1'b1, 16'h5F5E, 16'h0104, 3'd1};
        vt[7]  = '{1'b0, 1'b1, 16'h0107, 1'b1, 16'h5F5E, 16'h0104, 3'd1};
        vt[8]  = '{1'b0, 1'b1, 16'h0108, 1'b1, 16'h5F5E, 16'h0104, 3'd2};
        vt[9]  = '{1'b0, 1'b1, 16'h0109, 1'b1, 16'h5F5E, 16'h0104, 3'd2};
        vt[10] = '{1'b0, 1'b1, 16'h010A, 1'b1, 16'h5F5E, 16'h0104, 3'd3};
        vt[11] = '{1'b0, 1'b1, 16'h010B, 1'b1, 16'h5F5E, 16'h0104, 3'd3};
        vt[12] = '{1'b0, 1'b0, 16'h010B, 1'b1, 16'h5F5E, 16'h0104, 3'd4};
        vt[13] = '{1'b0, 1'b0, 16'h010B, 1'b1, 16'h5F5E, 16'h0104, 3'd4};
        vt[14] = '{1'b1, 1'b0, 16'h010B, 1'b1, 16'h6160, 16'h0106, 3'd3};
        vt[15] = '{1'b0, 1'b1, 16'h010C, 1'b1, 16'h6160, 16'h0106, 3'd3};
        vt[16] = '{1'b0, 1'b1, 16'h010D, 1'b1, 16'h6160, 16'h0106, 3'd3};
        vt[17] = '{1'b0, 1'b0, 16'h010D, 1'b1, 16'h6160, 16'h0106, 3'd4};
        vt[18] = '{1'b1, 1'b0, 16'h010D, 1'b1, 16'h6362, 16'h0108, 3'd3};
        vt[19] = '{1'b1, 1'b1, 16'h010E, 1'b1, 16'h6564, 16'h010A, 3'd2};
        vt[20] = '{1'b1, 1'b1, 16'h010F, 1'b1, 16'h6766, 16'h010C, 3'd1};
        vt[21] = '{1'b1, 1'b1, 16'h0110, 1'b1, 16'h6968, 16'h010E, 3'd1};

        reset_n     = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        wait_states = 0;
        step();
        step();
        chk("rst_req",   {31'd0, mem_req},     32'd0);
        chk("rst_addr",  {16'd0, mem_addr},    32'h0100);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_data",  {16'd0, instr_data},  32'd0);
        chk("rst_pc",    {16'd0, instr_pc},    32'd0);
        chk("rst_count", {29'd0, fifo_count},  32'd0);
        reset_n = 1'b1;

        // Streaming, backpressure to full, single-pop resume.
        for (int i = 0; i < 22; i++) begin
            instr_ready = vt[i].rdy;
            step();
            chk($sformatf("row%0d_req", i),   {31'd0, mem_req},     {31'd0, vt[i].req});
            chk($sformatf("row%0d_addr", i),  {16'd0, mem_addr},    {16'd0, vt[i].addr});
            chk($sformatf("row%0d_valid", i), {31'd0, instr_valid}, {31'd0, vt[i].vld});
            chk($sformatf("row%0d_count", i), {29'd0, fifo_count},  {29'd0, vt[i].cnt});
            if (vt[i].vld) begin
                chk($sformatf("row%0d_data", i), {16'd0, instr_data}, {16'd0, vt[i].data});
                chk($sformatf("row%0d_pc", i),   {16'd0, instr_pc},   {16'd0, vt[i].pc});
            end
        end

        // Redirect to odd target while high-byte read is stalled by wait states.
        instr_ready = 1'b0;
        do_reset(3);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (mem_req && mem_addr == 16'h0103) found = 1'b1;
        end
        chk("drain_seen_hi", {31'd0, found}, 32'd1);
        chk("drain_pre_count", {29'd0, fifo_count}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 16'h2001;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drain%0d_req", i),   {31'd0, mem_req},     32'd1);
            chk($sformatf("drain%0d_addr", i),  {16'd0, mem_addr},    32'h0103);
            chk($sformatf("drain%0d_count", i), {29'd0, fifo_count},  32'd0);
            chk($sformatf("drain%0d_valid", i), {31'd0, instr_valid}, 32'd0);
            step();
        end
        chk("drain_new_req",  {31'd0, mem_req},  32'd1);
        chk("drain_new_addr", {16'd0, mem_addr}, 32'h2000);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step();
            if (instr_valid) found = 1'b1;
        end
        chk("drain_first_valid", {31'd0, found},      32'd1);
        chk("drain_first_pc",    {16'd0, instr_pc},   32'h2000);
        chk("drain_first_data",  {16'd0, instr_data}, 32'h5B5A);

        // Redirect colliding with a high-byte ack and a pop.
        do_reset(0);
        repeat (4) step();
        chk("coll_pre_addr",  {16'd0, mem_addr},   32'h0103);
        chk("coll_pre_count", {29'd0, fifo_count}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 16'h3000;
        instr_ready = 1'b1;
        step();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        chk("coll_count", {29'd0, fifo_count},  32'd0);
        chk("coll_valid", {31'd0, instr_valid}, 32'd0);
        chk("coll_addr",  {16'd0, mem_addr},    32'h3000);
        chk("coll_req",   {31'd0, mem_req},     32'd1);
        step();
        step();
        chk("coll_first_pc",   {16'd0, instr_pc},   32'h3000);
        chk("coll_first_data", {16'd0, instr_data}, 32'h5B5A);

        // Address wrap at the top of memory.
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        chk("wrap_lo_addr", {16'd0, mem_addr}, 32'hFFFE);
        step();
        chk("wrap_hi_addr", {16'd0, mem_addr}, 32'hFFFF);
        step();
        chk("wrap_valid", {31'd0, instr_valid}, 32'd1);
        chk("wrap_pc",    {16'd0, instr_pc},    32'hFFFE);
        chk("wrap_data",  {16'd0, instr_data},  32'h5958);
        chk("wrap_next",  {16'd0, mem_addr},    32'h0000);

        // Asynchronous reset in the middle of a high-byte fetch.
        instr_ready = 1'b0;
        do_reset(0);
        repeat (6) step();
        chk("ar_pre_count", {29'd0, fifo_count}, 32'd2);
        chk("ar_pre_addr",  {16'd0, mem_addr},   32'h0105);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_req",   {31'd0, mem_req},     32'd0);
        chk("ar_addr",  {16'd0, mem_addr},    32'h0100);
        chk("ar_valid", {31'd0, instr_valid}, 32'd0);
        chk("ar_data",  {16'd0, instr_data},  32'd0);
        chk("ar_pc",    {16'd0, instr_pc},    32'd0);
        chk("ar_count", {29'd0, fifo_count},  32'd0);
        step();
        reset_n = 1'b1;
        step();
        chk("ar_restart_req",  {31'd0, mem_req},  32'd1);
        chk("ar_restart_addr", {16'd0, mem_addr}, 32'h0100);
        step();
        step();
        chk("ar_restart_pc",   {16'd0, instr_pc},   32'h0100);
        chk("ar_restart_data", {16'd0, instr_data}, 32'h1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
